// File: rtl/stage4_memory_pkg.sv
// Shared types for the memory stage: bus payloads, FSM states and RV32I
// load/store funct3 encodings.
package stage4_memory_pkg;

    localparam int unsigned REGISTER_WIDTH = 32;
    localparam int unsigned BYTE_LANES     = REGISTER_WIDTH / 8;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_funct3_e;

    typedef enum logic [2:0] {
        SB = 3'd0,
        SH = 3'd1,
        SW = 3'd2
    } store_funct3_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } decoded_instruction_t;

    typedef struct packed {
        decoded_instruction_t      decoded_instruction;
        logic [REGISTER_WIDTH-1:0] rs1_value;
        logic [REGISTER_WIDTH-1:0] rs2_value;
        logic [REGISTER_WIDTH-1:0] alu_result;
        logic                      branch_taken;
        logic [REGISTER_WIDTH-1:0] branch_target;
    } execute_to_memory_t;

    typedef struct packed {
        decoded_instruction_t      decoded_instruction;
        logic [REGISTER_WIDTH-1:0] alu_result;
        logic [REGISTER_WIDTH-1:0] mem_result;
        logic                      branch_taken;
        logic [REGISTER_WIDTH-1:0] branch_target;
        logic                      misaligned;
    } memory_to_writeback_t;

endpackage

// File: rtl/stage4_memory_load_store_align.sv
// Combinational byte-lane steering for RV32I loads and stores.
// Ports: i_is_store selects store vs load decode; i_funct3/i_offset are the
// access width and address[1:0]; i_store_data/i_load_word are the raw words.
// o_wstrb/o_wdata drive the store lanes, o_misaligned flags bad alignment or
// unsupported funct3, o_load_result is the extracted, extended load value.
module stage4_memory_load_store_align
    import stage4_memory_pkg::*;
(
    input  logic                      i_is_store,
    input  logic [2:0]                i_funct3,
    input  logic [1:0]                i_offset,
    input  logic [REGISTER_WIDTH-1:0] i_store_data,
    input  logic [REGISTER_WIDTH-1:0] i_load_word,
    output logic [BYTE_LANES-1:0]     o_wstrb,
    output logic [REGISTER_WIDTH-1:0] o_wdata,
    output logic                      o_misaligned,
    output logic [REGISTER_WIDTH-1:0] o_load_result
);

    logic [4:0]  w_shamt;
    logic [15:0] w_lane;

    assign w_shamt = {i_offset, 3'b000};
    // Addressed byte/half moved down to bit 0.
    assign w_lane  = 16'(i_load_word >> w_shamt);

    always_comb begin
        o_wstrb       = '0;
        o_wdata       = i_store_data << w_shamt;
        o_misaligned  = 1'b1;
        o_load_result = '0;
        if (i_is_store) begin
            case (i_funct3)
                SB: begin
                    o_wstrb      = BYTE_LANES'(1) << i_offset;
                    o_misaligned = 1'b0;
                end
                SH: begin
                    o_wstrb      = BYTE_LANES'(3) << i_offset;
                    o_misaligned = i_offset[0];
                end
                SW: begin
                    o_wstrb      = '1;
                    o_misaligned = |i_offset;
                end
                default: o_misaligned = 1'b1;
            endcase
        end else begin
            case (i_funct3)
                LB: begin
                    o_load_result = {{(REGISTER_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
                    o_misaligned  = 1'b0;
                end
                LBU: begin
                    o_load_result = {{(REGISTER_WIDTH-8){1'b0}}, w_lane[7:0]};
                    o_misaligned  = 1'b0;
                end
                LH: begin
                    o_load_result = {{(REGISTER_WIDTH-16){w_lane[15]}}, w_lane};
                    o_misaligned  = i_offset[0];
                end
                LHU: begin
                    o_load_result = {{(REGISTER_WIDTH-16){1'b0}}, w_lane};
                    o_misaligned  = i_offset[0];
                end
                LW: begin
                    o_load_result = i_load_word;
                    o_misaligned  = |i_offset;
                end
                default: o_misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/stage4_memory.sv
// Memory pipeline stage: passes ALU results through in one cycle and runs
// aligned loads/stores over a single-ported request/grant/rvalid bus.
// Ports: in_* valid/ready stream from execute, out_* valid/ready stream to
// writeback, dmem_* data-memory bus; rst is synchronous active-low.
module stage4_memory
    import stage4_memory_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_tvalid,
    output logic                      in_tready,
    input  execute_to_memory_t        in_tdata,
    output logic                      out_tvalid,
    input  logic                      out_tready,
    output memory_to_writeback_t      out_tdata,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [REGISTER_WIDTH-1:0] dmem_addr,
    output logic [REGISTER_WIDTH-1:0] dmem_wdata,
    output logic [BYTE_LANES-1:0]     dmem_wstrb,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [REGISTER_WIDTH-1:0] dmem_rdata
);

    mem_state_e                r_state, w_state_next;
    execute_to_memory_t        r_inst, w_inst_next;
    memory_to_writeback_t      r_out, w_out_next;
    logic                      r_out_valid, w_out_valid_next;
    logic                      r_req, w_req_next;
    logic                      r_we, w_we_next;
    logic [REGISTER_WIDTH-1:0] r_addr, w_addr_next;
    logic [REGISTER_WIDTH-1:0] r_wdata, w_wdata_next;
    logic [BYTE_LANES-1:0]     r_wstrb, w_wstrb_next;

    execute_to_memory_t        w_src;
    memory_to_writeback_t      w_result;
    logic                      w_is_load, w_is_store, w_is_mem, w_accept;
    logic [BYTE_LANES-1:0]     w_wstrb;
    logic [REGISTER_WIDTH-1:0] w_wdata, w_load_result;
    logic                      w_misaligned;
    logic                      w_unused;

    assign in_tready = (r_state == IDLE) && (!r_out_valid || out_tready);
    assign w_accept  = in_tvalid && in_tready;

    // Incoming instruction while idle, otherwise the one in flight.
    assign w_src      = (r_state == IDLE) ? in_tdata : r_inst;
    assign w_is_load  = (w_src.decoded_instruction.opcode == OPCODE_LOAD);
    assign w_is_store = (w_src.decoded_instruction.opcode == OPCODE_STORE);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_unused   = ^{w_src.rs1_value, w_src.rs2_value};

    stage4_memory_load_store_align u_align (
        .i_is_store   ((r_state == IDLE) && w_is_store),
        .i_funct3     (w_src.decoded_instruction.funct3),
        .i_offset     (w_src.alu_result[1:0]),
        .i_store_data (in_tdata.rs2_value),
        .i_load_word  (dmem_rdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .o_load_result(w_load_result)
    );

    // Writeback payload for whichever instruction completes this cycle.
    always_comb begin
        w_result                     = '0;
        w_result.decoded_instruction = w_src.decoded_instruction;
        w_result.alu_result          = w_src.alu_result;
        w_result.branch_taken        = w_src.branch_taken;
        w_result.branch_target       = w_src.branch_target;
        w_result.mem_result          = (r_state == RESP) ? w_load_result : '0;
        w_result.misaligned          = (r_state == IDLE) && w_is_mem && w_misaligned;
    end

    // Next-state and next-register values.
    always_comb begin
        w_state_next     = r_state;
        w_inst_next      = r_inst;
        w_out_next       = r_out;
        w_out_valid_next = r_out_valid && !out_tready;
        w_req_next       = r_req;
        w_we_next        = r_we;
        w_addr_next      = r_addr;
        w_wdata_next     = r_wdata;
        w_wstrb_next     = r_wstrb;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_mem && !w_misaligned) begin
                        w_state_next = REQ;
                        w_inst_next  = in_tdata;
                        w_req_next   = 1'b1;
                        w_we_next    = w_is_store;
                        w_addr_next  = {in_tdata.alu_result[REGISTER_WIDTH-1:2], 2'b00};
                        w_wdata_next = w_wdata;
                        w_wstrb_next = w_is_store ? w_wstrb : '0;
                    end else begin
                        w_out_next       = w_result;
                        w_out_valid_next = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    w_req_next   = 1'b0;
                    w_we_next    = 1'b0;
                    w_wstrb_next = '0;
                    if (r_we) begin
                        w_out_next       = w_result;
                        w_out_valid_next = 1'b1;
                        w_state_next     = IDLE;
                    end else begin
                        w_state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    w_out_next       = w_result;
                    w_out_valid_next = 1'b1;
                    w_state_next     = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_inst      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_inst      <= w_inst_next;
            r_out       <= w_out_next;
            r_out_valid <= w_out_valid_next;
            r_req       <= w_req_next;
            r_we        <= w_we_next;
            r_addr      <= w_addr_next;
            r_wdata     <= w_wdata_next;
            r_wstrb     <= w_wstrb_next;
        end
    end

    assign out_tvalid = r_out_valid;
    assign out_tdata  = r_out;
    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_wstrb = r_wstrb;

endmodule

// File: tb/tb_stage4_memory.sv
// Self-checking bench for stage4_memory: directed instructions, a scoreboard
// model of results/requests/latency, and a simple memory responder.
module tb_stage4_memory;
    import stage4_memory_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_tvalid;
    logic                 in_tready;
    execute_to_memory_t   in_tdata;
    logic                 out_tvalid;
    logic                 out_tready;
    memory_to_writeback_t out_tdata;
    logic                 dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0]          dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]           dmem_wstrb;

    always #5 clk = ~clk;

    stage4_memory dut (
        .clk(clk), .rst(rst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    typedef struct { memory_to_writeback_t o; int due; bit chk; } exp_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] wstrb; logic [31:0] wdata; } req_t;

    exp_t                 exp_q[$];
    req_t                 req_q[$];
    int                   checks = 0;
    int                   errors = 0;
    int                   cyc = 0;
    int                   gnt_wait = 0;
    int                   rsp_wait = 0;
    logic [31:0]          mem_word = 32'h0;
    logic                 rsp_we;
    memory_to_writeback_t last_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic execute_to_memory_t mk(logic [6:0] op, logic [2:0] f3,
                                              logic [31:0] alu, logic [31:0] rs2);
        execute_to_memory_t t = '0;
        t.decoded_instruction.opcode = op;
        t.decoded_instruction.funct3 = f3;
        t.decoded_instruction.rd     = 5'd7;
        t.decoded_instruction.rs1    = 5'd3;
        t.decoded_instruction.rs2    = 5'd4;
        t.rs1_value     = 32'h1111_0000;
        t.rs2_value     = rs2;
        t.alu_result    = alu;
        t.branch_taken  = alu[0];
        t.branch_target = alu + 32'h40;
        return t;
    endfunction

    // Access is rejected for unsupported funct3 or an address not a multiple of its size.
    function automatic bit acc_bad(bit st, logic [2:0] f3, logic [31:0] a);
        int sz;
        bit ok;
        sz = 1 << f3[1:0];
        ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !ok || ((int'(a[1:0]) % sz) != 0);
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * int'(a[1:0]));
        case (f3)
            3'd0: begin v &= 32'hFF;   if (v >= 32'd128)   v |= 32'hFFFF_FF00; end
            3'd1: begin v &= 32'hFFFF; if (v >= 32'd32768) v |= 32'hFFFF_0000; end
            3'd2: v = word;
            3'd4: v &= 32'hFF;
            3'd5: v &= 32'hFFFF;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Present one instruction, wait for acceptance, record expectations.
    task automatic send(execute_to_memory_t t, bit lat_chk);
        int   n = 0;
        int   lat, sz, off;
        bit   ld, st, bad;
        exp_t e;
        req_t r;
        in_tvalid = 1'b1;
        in_tdata  = t;
        @(negedge clk);
        while (in_tready !== 1'b1) begin
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout actual=stalled required=accept");
                in_tvalid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        ld  = (t.decoded_instruction.opcode == OPCODE_LOAD);
        st  = (t.decoded_instruction.opcode == OPCODE_STORE);
        bad = (ld || st) && acc_bad(st, t.decoded_instruction.funct3, t.alu_result);
        e.o = '0;
        e.o.decoded_instruction = t.decoded_instruction;
        e.o.alu_result    = t.alu_result;
        e.o.branch_taken  = t.branch_taken;
        e.o.branch_target = t.branch_target;
        e.o.misaligned    = bad;
        if (ld && !bad) e.o.mem_result = model_load(t.decoded_instruction.funct3, t.alu_result, mem_word);
        if (!(ld || st) || bad) lat = 1;
        else if (st)            lat = 2 + gnt_wait;
        else                    lat = 3 + gnt_wait + rsp_wait;
        e.due = cyc + lat;
        e.chk = lat_chk;
        exp_q.push_back(e);
        if ((ld || st) && !bad) begin
            sz      = 1 << t.decoded_instruction.funct3[1:0];
            off     = int'(t.alu_result[1:0]);
            r.addr  = t.alu_result & 32'hFFFF_FFFC;
            r.we    = st;
            r.wstrb = st ? 4'(((1 << sz) - 1) << off) : 4'h0;
            r.wdata = st ? (t.rs2_value << (8 * off)) : 32'h0;
            req_q.push_back(r);
        end
        @(posedge clk); #1;
        in_tvalid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory responder: grant after gnt_wait cycles, load data rsp_wait cycles later.
    initial begin
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (dmem_req === 1'b1) begin
                rsp_we = dmem_we;
                for (int i = 0; i < gnt_wait; i++) begin @(posedge clk); #1; end
                dmem_gnt = 1'b1;
                @(posedge clk); #1;
                dmem_gnt = 1'b0;
                if (!rsp_we) begin
                    for (int i = 0; i < rsp_wait; i++) begin @(posedge clk); #1; end
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = mem_word;
                    @(posedge clk); #1;
                    dmem_rvalid = 1'b0;
                    dmem_rdata  = 32'h0;
                end
            end
        end
    end

    // Compare process: requests at grant, results at handshake.
    always @(negedge clk) begin
        req_t r;
        exp_t e;
        logic [31:0] m;
        if (rst === 1'b1) begin
            if (dmem_req === 1'b1) chk("ready_while_req", 32'(in_tready), 32'h0);
            if (dmem_req === 1'b1 && dmem_gnt === 1'b1) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req actual=addr 0x%08h required=no request", dmem_addr);
                end else begin
                    r = req_q.pop_front();
                    m = 32'h0;
                    for (int i = 0; i < 4; i++) if (r.wstrb[i]) m[8*i +: 8] = 8'hFF;
                    chk("req_addr",  dmem_addr, r.addr);
                    chk("req_we",    32'(dmem_we), 32'(r.we));
                    chk("req_wstrb", 32'(dmem_wstrb), 32'(r.wstrb));
                    chk("req_wdata", dmem_wdata & m, r.wdata & m);
                end
            end
            if (out_tvalid === 1'b1 && out_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out actual=alu 0x%08h required=no output", out_tdata.alu_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_decoded",    32'(out_tdata.decoded_instruction), 32'(e.o.decoded_instruction));
                    chk("out_alu",        out_tdata.alu_result, e.o.alu_result);
                    chk("out_mem_result", out_tdata.mem_result, e.o.mem_result);
                    chk("out_branch",     32'(out_tdata.branch_taken), 32'(e.o.branch_taken));
                    chk("out_target",     out_tdata.branch_target, e.o.branch_target);
                    chk("out_misaligned", 32'(out_tdata.misaligned), 32'(e.o.misaligned));
                    if (e.chk) chk("out_latency", 32'(cyc), 32'(e.due));
                end
                last_out = out_tdata;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; in_tvalid = 1'b0; in_tdata = '0; out_tready = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_out_tvalid", 32'(out_tvalid), 32'h0);
        chk("rst_dmem_req",   32'(dmem_req), 32'h0);
        chk("rst_dmem_we",    32'(dmem_we), 32'h0);
        chk("rst_dmem_wstrb", 32'(dmem_wstrb), 32'h0);
        chk("rst_out_tdata",  32'(out_tdata != '0), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);

        // ALU pass-through, single then back-to-back.
        send(mk(OPCODE_OP_IMM, 3'd0, 32'h2A, 32'h0), 1'b1);
        idle(3);
        chk("addi_alu_literal", last_out.alu_result, 32'h2A);
        for (int i = 1; i <= 5; i++) send(mk(OPCODE_OP_IMM, 3'd0, 32'(i * 16), 32'h0), 1'b1);
        idle(3);
        chk("addi_burst_last", last_out.alu_result, 32'h50);

        // Stores.
        gnt_wait = 2;
        send(mk(OPCODE_STORE, 3'd0, 32'h103, 32'h1234_56AB), 1'b1);
        idle(8);
        gnt_wait = 0;
        send(mk(OPCODE_STORE, 3'd1, 32'h106, 32'h0000_BEEF), 1'b1);
        idle(4);
        send(mk(OPCODE_STORE, 3'd2, 32'h108, 32'hCAFE_F00D), 1'b1);
        idle(4);

        // Loads.
        mem_word = 32'h8001_0000;
        send(mk(OPCODE_LOAD, 3'd1, 32'h202, 32'h0), 1'b1);
        idle(6);
        chk("lh_literal", last_out.mem_result, 32'hFFFF_8001);
        send(mk(OPCODE_LOAD, 3'd5, 32'h202, 32'h0), 1'b1);
        idle(6);
        chk("lhu_literal", last_out.mem_result, 32'h0000_8001);
        mem_word = 32'h0000_7F00;
        rsp_wait = 2;
        send(mk(OPCODE_LOAD, 3'd0, 32'h201, 32'h0), 1'b1);
        idle(8);
        chk("lb_literal", last_out.mem_result, 32'h0000_007F);
        rsp_wait = 0;
        mem_word = 32'hDEAD_8000;
        send(mk(OPCODE_LOAD, 3'd0, 32'h301, 32'h0), 1'b1);
        idle(6);
        chk("lb_neg_literal", last_out.mem_result, 32'hFFFF_FF80);
        send(mk(OPCODE_LOAD, 3'd4, 32'h301, 32'h0), 1'b1);
        idle(6);
        send(mk(OPCODE_LOAD, 3'd2, 32'h304, 32'h0), 1'b1);
        idle(6);
        chk("lw_literal", last_out.mem_result, 32'hDEAD_8000);

        // Misaligned and unsupported accesses: no request, 1-cycle result.
        send(mk(OPCODE_LOAD, 3'd2, 32'h6, 32'h0), 1'b1);
        idle(3);
        chk("lw_misaligned_literal", 32'(last_out.misaligned), 32'h1);
        send(mk(OPCODE_LOAD, 3'd1, 32'h201, 32'h0), 1'b1);
        send(mk(OPCODE_STORE, 3'd2, 32'h102, 32'h5), 1'b1);
        send(mk(OPCODE_LOAD, 3'd3, 32'h200, 32'h0), 1'b1);
        send(mk(OPCODE_STORE, 3'd4, 32'h200, 32'h0), 1'b1);
        idle(4);

        // Held output blocks a new load for five stall cycles.
        out_tready = 1'b0;
        send(mk(OPCODE_OP_IMM, 3'd0, 32'h55, 32'h0), 1'b0);
        mem_word = 32'h1357_9BDF;
        fork
            send(mk(OPCODE_LOAD, 3'd2, 32'h400, 32'h0), 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", 32'(out_tvalid), 32'h1);
                    chk("hold_alu",   out_tdata.alu_result, 32'h55);
                    chk("hold_ready", 32'(in_tready), 32'h0);
                    chk("hold_noreq", 32'(dmem_req), 32'h0);
                end
                @(posedge clk); #1;
                out_tready = 1'b1;
            end
        join
        idle(8);
        chk("held_lw_literal", last_out.mem_result, 32'h1357_9BDF);

        // Reset while waiting for load data; the late rvalid must be ignored.
        rsp_wait = 5;
        mem_word = 32'hAAAA_AAAA;
        send(mk(OPCODE_LOAD, 3'd2, 32'h300, 32'h0), 1'b0);
        idle(2);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_resp_valid", 32'(out_tvalid), 32'h0);
        chk("rst_resp_req",   32'(dmem_req), 32'h0);
        chk("rst_resp_ready", 32'(in_tready), 32'h1);
        repeat (8) begin
            @(negedge clk);
            chk("late_rvalid_ignored", 32'(out_tvalid), 32'h0);
        end
        idle(2);
        rsp_wait = 0;
        mem_word = 32'h0BAD_F00D;
        send(mk(OPCODE_LOAD, 3'd2, 32'h500, 32'h0), 1'b1);
        idle(6);
        chk("post_rst_lw_literal", last_out.mem_result, 32'h0BAD_F00D);

        chk("pending_outputs",  32'(exp_q.size()), 32'h0);
        chk("pending_requests", 32'(req_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
